// File: rtl/uart_cmd_decoder.sv
// Turns UART command bytes into Pong paddle, serve, pause and game-reset controls.
// Each paddle holds its move level for HOLD_CLKS cycles after its last move byte.
module uart_cmd_decoder #(
    parameter int unsigned HOLD_CLKS = 2500000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_P1_Up,
    output logic       o_P1_Dn,
    output logic       o_P2_Up,
    output logic       o_P2_Dn,
    output logic       o_Start,
    output logic       o_Game_Rst,
    output logic       o_Paused,
    output logic       o_Err,
    output logic [3:0] o_Dbg_State
);

    localparam int CNT_W = $clog2(HOLD_CLKS + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CLKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        PAD_IDLE = 2'b00,
        PAD_UP   = 2'b01,
        PAD_DOWN = 2'b10
    } pad_state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_P1_UP,
        CMD_P1_DN,
        CMD_P2_UP,
        CMD_P2_DN,
        CMD_START,
        CMD_PAUSE,
        CMD_GRST,
        CMD_ERR
    } cmd_t;

    // Handshake: i_Rx_DV is a one-cycle strobe with no back-pressure; i_Rx_Byte is
    // only looked at in a cycle where i_Rx_DV=1, and every such cycle is decoded.
    cmd_t             cmd;
    pad_state_t       pad_state [2];
    logic [CNT_W-1:0] pad_cnt   [2];
    logic [1:0]       up_q;
    logic [1:0]       dn_q;
    logic [1:0]       load;
    logic [1:0]       load_up;
    logic             clear_all;

    always_comb begin
        cmd = CMD_NONE;
        if (i_Rx_DV) begin
            case (i_Rx_Byte)
                8'h77, 8'h57: cmd = CMD_P1_UP;
                8'h73, 8'h53: cmd = CMD_P1_DN;
                8'h69, 8'h49: cmd = CMD_P2_UP;
                8'h6B, 8'h4B: cmd = CMD_P2_DN;
                8'h20:        cmd = CMD_START;
                8'h70, 8'h50: cmd = CMD_PAUSE;
                8'h72, 8'h52: cmd = CMD_GRST;
                8'h0D, 8'h0A: cmd = CMD_NONE;
                default:      cmd = CMD_ERR;
            endcase
        end
    end

    // Move bytes are swallowed silently while paused.
    always_comb begin
        load      = 2'b00;
        load_up   = 2'b00;
        clear_all = 1'b0;
        case (cmd)
            CMD_P1_UP: begin load[0] = !o_Paused; load_up[0] = 1'b1; end
            CMD_P1_DN: load[0] = !o_Paused;
            CMD_P2_UP: begin load[1] = !o_Paused; load_up[1] = 1'b1; end
            CMD_P2_DN: load[1] = !o_Paused;
            CMD_PAUSE: clear_all = 1'b1;
            CMD_GRST:  clear_all = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pad_state[i] <= PAD_IDLE;
                pad_cnt[i]   <= '0;
            end
            up_q       <= 2'b00;
            dn_q       <= 2'b00;
            o_Start    <= 1'b0;
            o_Game_Rst <= 1'b0;
            o_Paused   <= 1'b0;
            o_Err      <= 1'b0;
        end else begin
            o_Start    <= (cmd == CMD_START);
            o_Game_Rst <= (cmd == CMD_GRST);
            o_Err      <= (cmd == CMD_ERR);

            if (cmd == CMD_PAUSE) begin
                o_Paused <= !o_Paused;
            end else if (cmd == CMD_START || cmd == CMD_GRST) begin
                o_Paused <= 1'b0;
            end

            // A move byte beats an expiring hold, so a reload never shows a gap.
            for (int i = 0; i < 2; i++) begin
                if (clear_all) begin
                    pad_state[i] <= PAD_IDLE;
                    pad_cnt[i]   <= '0;
                    up_q[i]      <= 1'b0;
                    dn_q[i]      <= 1'b0;
                end else if (load[i]) begin
                    pad_state[i] <= load_up[i] ? PAD_UP : PAD_DOWN;
                    pad_cnt[i]   <= HOLD_LOAD;
                    up_q[i]      <= load_up[i];
                    dn_q[i]      <= !load_up[i];
                end else if (pad_state[i] != PAD_IDLE) begin
                    if (pad_cnt[i] <= CNT_ONE) begin
                        pad_state[i] <= PAD_IDLE;
                        pad_cnt[i]   <= '0;
                        up_q[i]      <= 1'b0;
                        dn_q[i]      <= 1'b0;
                    end else begin
                        pad_cnt[i] <= pad_cnt[i] - CNT_ONE;
                    end
                end
            end
        end
    end

    assign o_P1_Up     = up_q[0];
    assign o_P1_Dn     = dn_q[0];
    assign o_P2_Up     = up_q[1];
    assign o_P2_Dn     = dn_q[1];
    assign o_Dbg_State = {pad_state[1], pad_state[0]};

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder with HOLD_CLKS=10: byte table, directed corner sequences,
// and random traffic against a remaining-hold-time model of both paddles.
module tb_uart_cmd_decoder;

    localparam int unsigned HOLD = 10;

    logic       i_Clock   = 1'b0;
    logic       i_Rst_n   = 1'b0;
    logic       i_Rx_DV   = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       o_P1_Up, o_P1_Dn, o_P2_Up, o_P2_Dn;
    logic       o_Start, o_Game_Rst, o_Paused, o_Err;
    logic [3:0] o_Dbg_State;
    logic [7:0] outs;

    uart_cmd_decoder #(.HOLD_CLKS(HOLD)) dut (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_Rx_DV    (i_Rx_DV),
        .i_Rx_Byte  (i_Rx_Byte),
        .o_P1_Up    (o_P1_Up),
        .o_P1_Dn    (o_P1_Dn),
        .o_P2_Up    (o_P2_Up),
        .o_P2_Dn    (o_P2_Dn),
        .o_Start    (o_Start),
        .o_Game_Rst (o_Game_Rst),
        .o_Paused   (o_Paused),
        .o_Err      (o_Err),
        .o_Dbg_State(o_Dbg_State)
    );

    // Bit order of every vector: {p1_up, p1_dn, p2_up, p2_dn, start, game_rst, paused, err}
    assign outs = {o_P1_Up, o_P1_Dn, o_P2_Up, o_P2_Dn, o_Start, o_Game_Rst, o_Paused, o_Err};

    always #5 i_Clock = ~i_Clock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_out;
    int         m_rem[2];
    bit         m_up[2];
    bit         m_paused;

    typedef struct {
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t       tbl[19];
    logic [7:0] pick[15] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h69, 8'h49, 8'h6B, 8'h4B,
                             8'h20, 8'h70, 8'h50, 8'h72, 8'h52, 8'h0D, 8'h0A};

    // Model: each paddle is "remaining cycles of assertion" plus a direction.
    function automatic logic [7:0] model_step(input bit dv, input logic [7:0] b);
        logic [7:0] c;
        int mv_pad;
        bit mv_up, start, grst, err, clear;
        mv_pad = -1; mv_up = 0; start = 0; grst = 0; err = 0; clear = 0;
        c = b;
        if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
        if (dv) begin
            case (c)
                "w":          begin mv_pad = 0; mv_up = 1; end
                "s":          mv_pad = 0;
                "i":          begin mv_pad = 1; mv_up = 1; end
                "k":          mv_pad = 1;
                " ":          begin start = 1; m_paused = 0; end
                "p":          begin m_paused = !m_paused; clear = 1; end
                "r":          begin grst = 1; m_paused = 0; clear = 1; end
                8'h0D, 8'h0A: ;
                default:      err = 1;
            endcase
        end
        for (int p = 0; p < 2; p++) begin
            if (clear) m_rem[p] = 0;
            else if (mv_pad == p && !m_paused) begin
                m_rem[p] = int'(HOLD);
                m_up[p]  = mv_up;
            end else if (m_rem[p] > 0) m_rem[p] = m_rem[p] - 1;
        end
        return {m_rem[0] > 0 && m_up[0], m_rem[0] > 0 && !m_up[0],
                m_rem[1] > 0 && m_up[1], m_rem[1] > 0 && !m_up[1],
                start, grst, m_paused, err};
    endfunction

    task automatic model_reset();
        m_rem[0] = 0; m_rem[1] = 0;
        m_up[0]  = 0; m_up[1]  = 0;
        m_paused = 0;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit dv, input logic [7:0] b, input string name);
        @(negedge i_Clock);
        i_Rx_DV   = dv;
        i_Rx_Byte = dv ? b : 8'($urandom_range(0, 255));
        exp_q.push_back(model_step(dv, b));
        @(posedge i_Clock);
        #1;
        last_out = outs;
        check(name, outs, exp_q.pop_front());
        i_Rx_DV = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_Clock);
        i_Rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", outs, 0);
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
    endtask

    initial begin
        int run;
        tbl[0]  = '{8'h77, 8'b1000_0000};
        tbl[1]  = '{8'h57, 8'b1000_0000};
        tbl[2]  = '{8'h73, 8'b0100_0000};
        tbl[3]  = '{8'h53, 8'b0100_0000};
        tbl[4]  = '{8'h69, 8'b0010_0000};
        tbl[5]  = '{8'h49, 8'b0010_0000};
        tbl[6]  = '{8'h6B, 8'b0001_0000};
        tbl[7]  = '{8'h4B, 8'b0001_0000};
        tbl[8]  = '{8'h20, 8'b0000_1000};
        tbl[9]  = '{8'h70, 8'b0000_0010};
        tbl[10] = '{8'h50, 8'b0000_0010};
        tbl[11] = '{8'h72, 8'b0000_0100};
        tbl[12] = '{8'h52, 8'b0000_0100};
        tbl[13] = '{8'h0D, 8'b0000_0000};
        tbl[14] = '{8'h0A, 8'b0000_0000};
        tbl[15] = '{8'h7A, 8'b0000_0001};
        tbl[16] = '{8'h00, 8'b0000_0001};
        tbl[17] = '{8'hFF, 8'b0000_0001};
        tbl[18] = '{8'h41, 8'b0000_0001};

        do_reset();
        check("dbg_state_reset", {28'd0, o_Dbg_State}, 0);

        // Each byte from a freshly reset block, response one edge after DV.
        for (int k = 0; k < 19; k++) begin
            do_reset();
            @(negedge i_Clock);
            i_Rx_DV   = 1'b1;
            i_Rx_Byte = tbl[k].b;
            @(posedge i_Clock);
            #1;
            check($sformatf("table_%02h", tbl[k].b), outs, tbl[k].exp);
            i_Rx_DV = 1'b0;
        end

        // Single move byte: exactly HOLD cycles of P1 up, P2 untouched.
        do_reset();
        run = 0;
        step(1, 8'h77, "p1_up_byte");
        if (last_out[7]) run++;
        repeat (12) begin
            step(0, 8'h00, "p1_up_hold");
            if (last_out[7]) run++;
        end
        check("p1_up_length", run, HOLD);

        // Retrigger extends the hold; opposite byte reverses on the same edge.
        run = 0;
        step(1, 8'h53, "p1_dn_first");
        if (last_out[6]) run++;
        repeat (4) begin
            step(0, 8'h00, "p1_dn_hold");
            if (last_out[6]) run++;
        end
        step(1, 8'h73, "p1_dn_retrigger");
        if (last_out[6]) run++;
        repeat (12) begin
            step(0, 8'h00, "p1_dn_hold2");
            if (last_out[6]) run++;
        end
        check("p1_dn_run_length", run, 15);
        step(1, 8'h53, "p1_dn_again");
        repeat (3) step(0, 8'h00, "p1_dn_wait");
        step(1, 8'h57, "p1_reverse");
        check("p1_reverse_bits", last_out[7:6], 2'b10);

        // Pause blocks moves without error; start clears pause.
        do_reset();
        step(1, 8'h70, "pause_on");
        step(1, 8'h6B, "move_while_paused");
        check("paused_no_move_no_err", {last_out[4], last_out[1], last_out[0]}, 3'b010);
        step(1, 8'h20, "start_byte");
        check("start_pulse_unpause", {last_out[3], last_out[1]}, 2'b10);
        step(0, 8'h00, "after_start");
        check("start_single_pulse", last_out[3], 1'b0);

        // Back-to-back DV bytes each decoded independently.
        step(1, 8'h7A, "err_byte");
        check("err_pulse", last_out, 8'b0000_0001);
        step(1, 8'h0D, "cr_byte");
        check("cr_silent", last_out, 8'b0000_0000);
        step(1, 8'h52, "grst_byte");
        check("grst_pulse", last_out, 8'b0000_0100);
        step(0, 8'h00, "after_grst");

        // Asynchronous reset mid-hold, then normal decoding again.
        step(1, 8'h69, "p2_up_byte");
        repeat (3) step(0, 8'h00, "p2_up_hold");
        #3;
        i_Rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_mid_hold", outs, 0);
        @(negedge i_Clock);
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        repeat (3) step(0, 8'h00, "post_reset_idle");
        step(1, 8'h77, "post_reset_first_dv");

        // Move byte on the exact expiry cycle: no gap in P2 down.
        do_reset();
        run = 0;
        step(1, 8'h4B, "p2_dn_first");
        if (last_out[4]) run++;
        repeat (9) begin
            step(0, 8'h00, "p2_dn_hold");
            if (last_out[4]) run++;
        end
        step(1, 8'h4B, "p2_dn_at_expiry");
        if (last_out[4]) run++;
        repeat (12) begin
            step(0, 8'h00, "p2_dn_hold2");
            if (last_out[4]) run++;
        end
        check("p2_dn_no_gap_length", run, 2 * HOLD);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit         dv;
            logic [7:0] b;
            dv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(0, 255));
            else b = pick[$urandom_range(0, 14)];
            step(dv, b, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
